// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer definitions: frame geometry defaults, pixel FIFO entry
// and the framebuffer address helper also used by the display reader.
package vga_pkg;

  localparam int unsigned HDISP_DEF = 640;
  localparam int unsigned VDISP_DEF = 480;
  localparam int unsigned RGB565_W  = 16;
  localparam int unsigned WB_ADR_W  = 32;

  typedef struct packed {
    logic                sof;
    logic [RGB565_W-1:0] data;
  } fifo_entry_t;

  localparam int unsigned FIFO_ENTRY_W = $bits(fifo_entry_t);

  typedef enum logic {
    WAIT_SOF,
    RUN
  } in_state_t;

  // Byte address of pixel (x,y): two bytes per RGB565 pixel, row-major.
  function automatic logic [WB_ADR_W-1:0] fb_addr(
    input logic [WB_ADR_W-1:0] base,
    input logic [WB_ADR_W-1:0] hdisp,
    input logic [WB_ADR_W-1:0] x,
    input logic [WB_ADR_W-1:0] y
  );
    return base + ((hdisp * y + x) << 1);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle for 16-bit framebuffer accesses.
interface wshb_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32
);

  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_ms;
  logic            ack;

  modport master (output cyc, stb, we, sel, cti, bte, adr, dat_ms, input ack);
  modport slave  (input cyc, stb, we, sel, cti, bte, adr, dat_ms, output ack);

endinterface

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry.
module fifo_sync #(
  parameter int unsigned DATA_WIDTH  = 17,
  parameter int unsigned DEPTH_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;
  localparam int unsigned PW    = DEPTH_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                 (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);
  assign rdata = mem[rd_ptr[DEPTH_WIDTH-1:0]];

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/fb_writer.sv
// Writes an RGB565 pixel stream into the SDRAM framebuffer via Wishbone,
// one single write per pixel, tracking the frame position of each pixel.
module fb_writer
  import vga_pkg::*;
#(
  parameter int unsigned          HDISP     = HDISP_DEF,
  parameter int unsigned          VDISP     = VDISP_DEF,
  parameter logic [WB_ADR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned          FIFO_AW   = 4
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [RGB565_W-1:0] pix_data,
  input  logic                pix_sof,
  wshb_if.master              wshb_ifm,
  output logic                frame_done,
  output logic                sof_err,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned YW = $clog2(VDISP);

  in_state_t                 state_q;
  in_state_t                 state_d;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  fifo_entry_t               push_entry;
  fifo_entry_t               head;
  logic [FIFO_ENTRY_W-1:0]   head_raw;
  logic [XW-1:0]             x_q;
  logic [YW-1:0]             y_q;
  logic [XW-1:0]             ex;
  logic [YW-1:0]             ey;
  logic [XW-1:0]             x_nxt;
  logic [YW-1:0]             y_nxt;
  logic                      at_last_x;
  logic                      at_last_y;

  always_ff @(posedge CLK) begin
    if (!NRST) state_q <= WAIT_SOF;
    else       state_q <= state_d;
  end

  // Input side: discard everything until the first start-of-frame pixel.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    push      = 1'b0;
    if (NRST) begin
      case (state_q)
        WAIT_SOF: begin
          pix_ready = 1'b1;
          if (pix_valid && pix_sof) begin
            push    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          pix_ready = !fifo_full;
          push      = pix_valid && !fifo_full;
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  assign push_entry = '{sof: pix_sof, data: pix_data};

  fifo_sync #(
    .DATA_WIDTH  (FIFO_ENTRY_W),
    .DEPTH_WIDTH (FIFO_AW)
  ) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = fifo_entry_t'(head_raw);
  assign pop  = wshb_ifm.ack && !fifo_empty;

  // A SOF entry always lands at (0,0), resyncing the position counters.
  assign ex        = head.sof ? '0 : x_q;
  assign ey        = head.sof ? '0 : y_q;
  assign at_last_x = (ex == XW'(HDISP - 1));
  assign at_last_y = (ey == YW'(VDISP - 1));
  assign x_nxt     = at_last_x ? '0 : ex + XW'(1);
  assign y_nxt     = at_last_x ? (at_last_y ? '0 : ey + YW'(1)) : ey;

  assign wshb_ifm.cyc    = !fifo_empty;
  assign wshb_ifm.stb    = !fifo_empty;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 2'b11;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;
  assign wshb_ifm.dat_ms = head.data;
  assign wshb_ifm.adr    = fb_addr(BASE_ADDR, WB_ADR_W'(HDISP), WB_ADR_W'(ex), WB_ADR_W'(ey));

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      x_q        <= '0;
      y_q        <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= pop && at_last_x && at_last_y;
      sof_err    <= pop && head.sof && ((x_q != '0) || (y_q != '0));
      if (pop) begin
        x_q <= x_nxt;
        y_q <= y_nxt;
        if (at_last_x && at_last_y) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Wishbone master that writes an incoming RGB565 pixel stream into the SDRAM framebuffer, using the same layout the VGA display path reads: byte address 2*(HDISP*y + x) + BASE_ADDR. Pixels enter through a valid/ready stream with a start-of-frame flag and are buffered in a small synchronous FIFO. They are then written one Wishbone single write per pixel, with frame-position counters that wrap at the frame end. The block sits between a pixel source (camera/generator) and the SDRAM controller's Wishbone slave, alongside the display reader.

## Interface
Clock is CLK; reset is NRST, synchronous and active-low. Both are fixed decisions.

Parameters:
- HDISP, 640: pixels per line.
- VDISP, 480: lines per frame.
- BASE_ADDR, 0: framebuffer byte base address.
- FIFO_AW, 4: FIFO address width; depth is 2**FIFO_AW.

Ports:
- CLK  in  1  single clock; all logic and Wishbone are synchronous to it.
- NRST  in  1  synchronous active-low reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  block accepts the pixel when pix_valid & pix_ready.
- pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- pix_sof  in  1  marks the first pixel of a frame.
- wshb_ifm  wshb_if.master  —  Wishbone master, clocked by CLK.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is acked.
- sof_err  out  1  one-cycle pulse when a SOF pixel is written while the counters are not at (0,0).
- frame_cnt  out  16  count of completed frames; wraps at 65535 → 0.

## Operation
- Input FSM, two states:
  - WAIT_SOF (reset state): pix_ready=1 and accepted pixels are dropped. An accepted pixel with pix_sof=1 is pushed and the FSM moves to RUN.
  - RUN: pix_ready = !fifo_full. Every accepted pixel is pushed as {sof, data}, 17 bits. The FSM never leaves RUN except by reset.
- Wishbone side is combinational from the FIFO head (show-ahead):
  - cyc = stb = !fifo_empty.
  - we=1, sel=2'b11, cti=0, bte=0.
  - dat_ms = head data.
  - adr = BASE_ADDR + 2*(HDISP*ey + ex), where (ex,ey) = head.sof ? (0,0) : (x,y).
- On ack:
  - Pop the FIFO.
  - Set (x,y) to the successor of (ex,ey): x+1; at x=HDISP-1, x=0 and y+1; at y=VDISP-1 as well, y=0.
- frame_done and frame_cnt++ occur when the acked pixel has (ex,ey) = (HDISP-1, VDISP-1).
- sof_err fires when the acked entry has sof=1 and (x,y)≠(0,0). The write still goes to address BASE_ADDR, i.e. the counters resync.
- Arithmetic: x is $clog2(HDISP) bits and y is $clog2(VDISP) bits. The address is computed in 32 bits with no truncation.
- Request signals stay stable while stb=1 and ack=0; the FIFO head does not change because there is no pop.

## Timing
- Reset: while NRST=0 at a CLK edge, the FSM goes to WAIT_SOF, the FIFO empties, x=y=0, frame_cnt=0, frame_done=sof_err=0.
  - Hence cyc=stb=0 from the cycle after the edge.
  - pix_ready is forced to 0 while NRST=0.
- Reset mid-transfer abandons the outstanding write. A late ack with an empty FIFO is ignored.
- Latency: a pixel accepted in cycle n shows stb=1 in cycle n+1.
- Throughput: ack in cycle m pops at the m edge. If the FIFO is still non-empty, stb stays 1 in m+1 with the next pixel, so one write per cycle is possible.
- Full FIFO: pix_ready=0 even if a pop happens in the same cycle; there is no push-through when full.
- Empty FIFO with a push in the same cycle: stb=1 the next cycle.
- Simultaneous push and pop when not full: both happen, and the occupancy is unchanged.
- frame_done, sof_err and frame_cnt are registered: they update in the cycle after the qualifying ack.

## Structure
- Package vga_pkg:
  - HDISP/VDISP defaults.
  - RGB565 width constant.
  - Typedef of the 17-bit FIFO entry {logic sof; logic [15:0] data}.
  - fb_addr(x,y) function, shared with the display reader.
- Sub-module fifo_sync: single-clock, show-ahead, with DATA_WIDTH and DEPTH_WIDTH parameters, synchronous active-low reset, and full/empty flags.

## Test plan
- Reset, then pixel 0x1234 with sof=1 and ack tied 1 → stb=1 next cycle, adr=0x0, dat_ms=0x1234, we=1, sel=2'b11.
- Pixels before any SOF (3 pixels, sof=0) → all accepted with pix_ready=1, and no Wishbone cycle occurs.
- Full frame with HDISP=4, VDISP=2 and ack always 1 → 8 writes at adr 0,2,…,14; frame_done pulses once the cycle after the 8th ack; frame_cnt=1; the 9th pixel (no SOF) goes to adr 0.
- Ack held 0 with the source streaming (FIFO_AW=2) → exactly 4 pixels accepted, then pix_ready=0; adr/dat_ms stay stable; releasing ack drains 4 writes in 4 consecutive cycles.
- SOF at pixel index 3 of a frame → that write goes to adr 0, sof_err pulses once, and the next pixel goes to adr 2.
- NRST low for one cycle while stb=1 and ack=0 → cyc=stb=0 next, the FSM is in WAIT_SOF, and the following non-SOF pixels are dropped.
